// File: rtl/cla16_drv.sv
// Handshake driver around an external two-stage registered 16-bit adder.
// Optional shadow checker enabled by defining CLA16_DRV_CHECK_EN.
module cla16_drv #(
  parameter int W     = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [W-1:0]     s_a,
  input  logic [W-1:0]     s_b,
  output logic             add_en,
  output logic [W-1:0]     add_a,
  output logic [W-1:0]     add_b,
  input  logic [W-1:0]     add_res,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [W-1:0]     m_res,
  output logic             busy,
  output logic [CNT_W-1:0] in_cnt,
  output logic [CNT_W-1:0] out_cnt,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t state, state_nxt;
  logic   v1, v2;
  logic   stall, acc, dlv;

  assign stall = v2 && !m_ready;
  assign acc   = s_valid && s_ready;
  assign dlv   = m_valid && m_ready;
  assign add_a = s_a;
  assign add_b = s_b;
  assign m_res = add_res;

  // Occupancy moves in lockstep with the adder registers, so both freeze on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else if (add_en) begin
      v2 <= v1;
      v1 <= acc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (acc) state_nxt = RUN;
      RUN: begin
        if (stall)            state_nxt = HOLD;
        else if (!v1 && !acc) state_nxt = IDLE;
      end
      HOLD: begin
        if (!stall) state_nxt = (!v1 && !acc) ? IDLE : RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are masked during reset so a stale v2 is never presented.
  always_comb begin
    add_en  = !stall && !rst;
    s_ready = !stall && !rst;
    m_valid = v2 && !rst;
    busy    = (state != IDLE) && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      if (acc) in_cnt  <= in_cnt + 1'b1;
      if (dlv) out_cnt <= out_cnt + 1'b1;
    end
  end

`ifdef CLA16_DRV_CHECK_EN
  logic [W-1:0] sh1, sh2;
  logic         err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh1   <= '0;
      sh2   <= '0;
      err_q <= 1'b0;
    end else begin
      if (add_en) begin
        sh1 <= s_a + s_b;
        sh2 <= sh1;
      end
      if (dlv && (m_res != sh2)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cla16_drv.sv
// Bench for cla16_drv: models the registered adder, scoreboards every delivery.
module tb_cla16_drv;
  localparam int W     = 16;
  localparam int CNT_W = 16;
`ifdef CLA16_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             s_valid = 1'b0;
  logic             m_ready = 1'b0;
  logic [W-1:0]     s_a = '0, s_b = '0;
  logic             s_ready, add_en, m_valid, busy, err;
  logic [W-1:0]     add_a, add_b, add_res, m_res;
  logic [CNT_W-1:0] in_cnt, out_cnt;

  logic [W-1:0] ar_a = '0, ar_b = '0, sum_q = '0;
  logic         flip = 1'b0;
  logic [W-1:0] sb[$];
  logic [W-1:0] mon_exp;
  int checks = 0, errors = 0;

  cla16_drv #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
    .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_res(add_res),
    .m_valid(m_valid), .m_ready(m_ready), .m_res(m_res), .busy(busy),
    .in_cnt(in_cnt), .out_cnt(out_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // External adder: input and output registers both advance on add_en.
  always @(posedge clk) begin
    if (add_en) begin
      ar_a  <= add_a;
      ar_b  <= add_b;
      sum_q <= ar_a + ar_b;
    end
  end
  assign add_res = sum_q ^ {{(W-1){1'b0}}, flip};

  // Handshakes are stable at negedge and fire on the following posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && m_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL sb_extra got %h expected none", m_res);
        end else begin
          mon_exp = sb.pop_front() ^ {{(W-1){1'b0}}, flip};
          if (m_res !== mon_exp) begin
            errors++; $display("FAIL sb_result got %h want %h", m_res, mon_exp);
          end
        end
      end
      if (s_valid && s_ready) sb.push_back(W'(s_a + s_b));
    end
  end

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && (sb.size() != 0 || busy); n++) next_cyc();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL drain pending %0d want 0", sb.size()); end
    checks++; if (in_cnt !== out_cnt) begin errors++; $display("FAIL drain_cnt in %h out %h", in_cnt, out_cnt); end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    next_cyc();
    @(negedge clk);
    checks++; if (add_en  !== 1'b0) begin errors++; $display("FAIL rst_add_en got %b want 0", add_en); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got %b want 0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got %b want 0", m_valid); end
    checks++; if (busy    !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (in_cnt  !== '0)   begin errors++; $display("FAIL rst_in_cnt got %h want 0", in_cnt); end
    checks++; if (out_cnt !== '0)   begin errors++; $display("FAIL rst_out_cnt got %h want 0", out_cnt); end
    checks++; if (err     !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err); end
    next_cyc();
    rst = 1'b0; sb.delete();
  endtask

  task automatic test_single();
    s_valid = 1'b1; s_a = 16'h1234; s_b = 16'h0001; m_ready = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL single_s_ready got %b want 1", s_ready); end
    next_cyc(); s_valid = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_c1_valid got %b want 0", m_valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_c1_busy got %b want 1", busy); end
    next_cyc();
    @(negedge clk);
    checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_c2_valid got %b want 1", m_valid); end
    checks++; if (m_res !== 16'h1235) begin errors++; $display("FAIL single_res got %h want 1235", m_res); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_c2_busy got %b want 1", busy); end
    next_cyc();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_c3_valid got %b want 0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_c3_busy got %b want 0", busy); end
    checks++; if (in_cnt !== 16'd1 || out_cnt !== 16'd1) begin
      errors++; $display("FAIL single_cnt got %0d/%0d want 1/1", in_cnt, out_cnt);
    end
    next_cyc();
  endtask

  task automatic test_wrap();
    s_valid = 1'b1; s_a = 16'hFFFF; s_b = 16'h0002; m_ready = 1'b1;
    next_cyc(); s_valid = 1'b0;
    next_cyc();
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_res !== 16'h0001) begin
      errors++; $display("FAIL wrap_res got v=%b %h want v=1 0001", m_valid, m_res);
    end
    next_cyc();
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL wrap_err got %b want 0", err); end
    next_cyc();
  endtask

  task automatic test_back_to_back();
    int bad_rdy = 0, bad_out = 0;
    m_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin s_valid = 1'b1; s_a = W'(k); s_b = W'(2*k); end
      else s_valid = 1'b0;
      @(negedge clk);
      if (k < 8 && s_ready !== 1'b1) bad_rdy++;
      if (k >= 2 && k < 10) begin
        if (m_valid !== 1'b1 || m_res !== W'(3*(k-2))) begin
          bad_out++; $display("FAIL b2b_out k=%0d got v=%b %h want v=1 %h", k, m_valid, m_res, W'(3*(k-2)));
        end
      end else if (m_valid !== 1'b0) begin
        bad_out++; $display("FAIL b2b_idle k=%0d got v=%b want 0", k, m_valid);
      end
      next_cyc();
    end
    checks++; if (bad_rdy != 0) begin errors++; $display("FAIL b2b_s_ready drops %0d want 0", bad_rdy); end
    checks++; if (bad_out != 0) errors++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    int bad = 0;
    m_ready = 1'b1;
    s_valid = 1'b1; s_a = 16'h0100; s_b = 16'h0011; next_cyc();
    s_a = 16'h0200; s_b = 16'h0022; next_cyc();
    s_a = 16'h0300; s_b = 16'h0033; m_ready = 1'b0;
    held = 16'h0111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (add_en !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b1 || m_res !== held) begin
        bad++; $display("FAIL bp_stall k=%0d en=%b rdy=%b v=%b res=%h want 0 0 1 %h", k, add_en, s_ready, m_valid, m_res, held);
      end
      if (k == 0 && CNT_W'(in_cnt - out_cnt) !== CNT_W'(2)) begin
        bad++; $display("FAIL bp_inflight got %0d want 2", CNT_W'(in_cnt - out_cnt));
      end
      next_cyc();
    end
    checks++; if (bad != 0) errors++;
    m_ready = 1'b1;
    @(negedge clk);
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_rdy got %b want 1", s_ready); end
    next_cyc(); s_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_midflight();
    int stale = 0;
    m_ready = 1'b1;
    s_valid = 1'b1; s_a = 16'h0AAA; s_b = 16'h0001; next_cyc();
    s_a = 16'h0BBB; s_b = 16'h0002; next_cyc();
    s_valid = 1'b0; rst = 1'b1; sb.delete();
    @(negedge clk);
    checks++; if (m_valid !== 1'b0 || add_en !== 1'b0) begin
      errors++; $display("FAIL mid_rst got v=%b en=%b want 0 0", m_valid, add_en);
    end
    next_cyc(); rst = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_after got v=%b busy=%b want 0 0", m_valid, busy);
    end
    checks++; if (in_cnt !== '0 || out_cnt !== '0) begin
      errors++; $display("FAIL mid_cnt got %0d/%0d want 0/0", in_cnt, out_cnt);
    end
    for (int k = 0; k < 4; k++) begin next_cyc(); @(negedge clk); if (m_valid !== 1'b0) stale++; end
    checks++; if (stale != 0) begin errors++; $display("FAIL mid_stale got %0d want 0", stale); end
    next_cyc();
    s_valid = 1'b1; s_a = 16'h4000; s_b = 16'h0321; next_cyc(); s_valid = 1'b0;
    drain();
  endtask

  task automatic test_checker();
    m_ready = 1'b1; flip = 1'b1;
    s_valid = 1'b1; s_a = 16'h5555; s_b = 16'h1111; next_cyc(); s_valid = 1'b0;
    next_cyc(); next_cyc(); flip = 1'b0;
    @(negedge clk);
    checks++; if (err !== CHK) begin errors++; $display("FAIL chk_set got %b want %b", err, CHK); end
    s_valid = 1'b1; s_a = 16'h0007; s_b = 16'h0008; next_cyc(); s_valid = 1'b0;
    drain();
    checks++; if (err !== CHK) begin errors++; $display("FAIL chk_sticky got %b want %b", err, CHK); end
    rst = 1'b1; next_cyc(); rst = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL chk_clear got %b want 0", err); end
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_checker();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla16_drv.md
CLA16_DRV -- requirements
Module: cla16_drv

Interface
REQ-001 Parameter: W, 16, operand and result width; the only supported value is 16.
REQ-002 Parameter: CNT_W, 16, width of the transaction counters.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous, active-high reset; one clock; the reset is synchronous and active-high.
REQ-005 s_valid  input  1  upstream operand pair valid.
REQ-006 s_ready  output  1  upstream operand pair accepted when s_valid&&s_ready at clk edge.
REQ-007 s_a, s_b  input  W  operand pair.
REQ-008 add_en  output  1  enable to the registered 16-bit adder (advances its input and output registers together).
REQ-009 add_a, add_b  output  W  operands to the adder.
REQ-010 add_res  input  W  adder registered sum; valid 2 enabled edges after operands were captured.
REQ-011 m_valid  output  1  result valid to downstream.
REQ-012 m_ready  input  1  downstream accepts result when m_valid&&m_ready at clk edge.
REQ-013 m_res  output  W  result, equals add_res.
REQ-014 busy  output  1  one or more operand pairs are in flight.
REQ-015 in_cnt, out_cnt  output  CNT_W  accepted-pair and delivered-result counts.
REQ-016 err  output  1  sticky mismatch flag (see Configuration).

Function
REQ-017 Occupancy bits: v1 = adder input register holds a live pair; v2 = adder output register holds a live result.
REQ-018 stall = v2 && !m_ready; add_en = !stall && !rst; s_ready = !stall && !rst.
REQ-019 add_a/add_b = s_a/s_b combinationally; the adder captures them only on an edge with add_en=1.
REQ-020 On an add_en edge: v2 <= v1; v1 <= s_valid && s_ready; while stalled, v1 and v2 hold.
REQ-021 m_valid = v2; m_res = add_res; latency from acceptance to m_valid is exactly 2 cycles when unstalled.
REQ-022 Throughput: one pair per cycle when m_ready is held high; no bubbles inserted.
REQ-023 While m_valid=1 and m_ready=0, m_res stays stable and no pair is accepted; the adder is frozen via add_en=0.
REQ-024 Sum is (s_a+s_b) mod 2^16; the carry-out is discarded.
REQ-025 State machine: IDLE (v1=v2=0), RUN (any v set, not stalled), HOLD (stall=1). IDLE->RUN on acceptance; RUN->HOLD when v2&&!m_ready; HOLD->RUN on m_ready; RUN->IDLE when the last result is delivered and nothing new is accepted.
REQ-026 busy = (state != IDLE).
REQ-027 in_cnt increments on each acceptance; out_cnt increments on each delivery; both wrap 0xFFFF->0x0000; acceptance and delivery in the same cycle update both counters.
REQ-028 Invariant: in_cnt - out_cnt (mod 2^CNT_W) equals v1+v2, never more than 2.

Reset
REQ-029 rst sampled high: v1=v2=0, state=IDLE, in_cnt=out_cnt=0, err=0, and any check pipeline is cleared.
REQ-030 During rst: add_en=0, s_ready=0, m_valid=0, busy=0.
REQ-031 Reset mid-operation discards in-flight pairs; no result from them is ever presented, whatever add_res holds.
REQ-032 First acceptance is possible on the first edge after rst deasserts.

Configuration
REQ-033 Macro CLA16_DRV_CHECK_EN: when defined, a shadow 2-stage pipeline advanced by add_en carries s_a+s_b mod 2^16.
REQ-034 With CLA16_DRV_CHECK_EN defined, on each delivery where m_res differs from the shadow value, err is set and stays set until rst.
REQ-035 Without CLA16_DRV_CHECK_EN, the shadow pipeline is absent and err is tied to 0.

Verification
REQ-036 Single pair: pair 0x1234+0x0001 accepted at cycle 0, m_ready=1 -> m_valid=1 at cycle 2 with m_res=0x1235; busy 1 for cycles 1-2; counts 1/1.
REQ-037 Wrap: pair 0xFFFF+0x0002 -> m_res=0x0001; with the macro defined, err=0.
REQ-038 Streaming: 8 back-to-back pairs (i, 2i), m_ready=1 -> 8 consecutive results 3i starting 2 cycles after the first acceptance; s_ready stays 1.
REQ-039 Backpressure: m_ready=0 for 5 cycles while 3 pairs are pending -> add_en=0, s_ready=0, m_res stable; on release, results are delivered in order with none lost or duplicated.
REQ-040 Reset mid-flight: rst asserted with v1=v2=1 -> m_valid=0 the next cycle, counts 0, and no stale result after release.
REQ-041 Checker (macro defined): force add_res bit 0 inverted on delivery -> err=1, held until rst.
